// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, access-size encodings and size helper for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: gathers eight wrapping bytes from the flat store and sign/zero-extends by funct3
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int AW = $clog2(DEPTH_BYTES)
) (
  input  logic [8*DEPTH_BYTES-1:0] mem,
  input  logic [AW-1:0]            idx,
  input  logic [2:0]               funct3,
  output logic [63:0]              rdata
);
  logic [63:0] raw;
  logic        sx;
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[{AW'(idx + AW'(i)), 3'b000} +: 8];
    sx = ~funct3[2];
    rdata = funct3[1:0] == SZ_B ? {{56{sx & raw[7]}}, raw[7:0]} :
            funct3[1:0] == SZ_H ? {{48{sx & raw[15]}}, raw[15:0]} :
            funct3[1:0] == SZ_W ? {{32{sx & raw[31]}}, raw[31:0]} : raw;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with programmable wait states and one outstanding access
// Define DMEM_MISALIGN_CHK_EN to fault misaligned accesses instead of wrapping them bytewise.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  dbg_byte0,
  output logic [7:0]  dbg_byte1,
  output logic [7:0]  dbg_byte2,
  output logic [7:0]  dbg_byte3,
  output logic [7:0]  dbg_byte4,
  output logic [7:0]  dbg_byte5
);
  localparam int AW = $clog2(DEPTH_BYTES);
  state_t                   state;
  logic [3:0]               cnt;
  logic [8*DEPTH_BYTES-1:0] mem;
  logic                     we_q;
  logic [AW-1:0]            idx_q;
  logic [63:0]              wdata_q;
  logic [2:0]               f3_q;
  logic                     c_we;
  logic [AW-1:0]            c_idx;
  logic [63:0]              c_wdata;
  logic [2:0]               c_f3;
  logic [3:0]               nb;
  logic [63:0]              ld_data;
  logic                     accept;
  logic                     commit;
  logic                     mis;
  logic                     unused_addr;
  assign unused_addr = ^req_addr[63:AW];
  assign req_ready = state == IDLE && reset;
  assign accept = req_valid && req_ready;
  // With zero wait states the commit happens on the accept edge itself, so use the live request
  assign c_we    = state == IDLE ? req_we : we_q;
  assign c_idx   = state == IDLE ? req_addr[AW-1:0] : idx_q;
  assign c_wdata = state == IDLE ? req_wdata : wdata_q;
  assign c_f3    = state == IDLE ? req_funct3 : f3_q;
  assign nb      = size_bytes(c_f3);
  assign commit  = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
`ifdef DMEM_MISALIGN_CHK_EN
  logic [2:0] mask;
  assign mask = 3'(nb - 4'd1);
  assign mis  = |(c_idx[2:0] & mask);
`else
  assign mis = 1'b0;
`endif
  dmem_lane_align #(.DEPTH_BYTES(DEPTH_BYTES), .AW(AW)) u_align (
    .mem(mem),
    .idx(c_idx),
    .funct3(c_f3),
    .rdata(ld_data)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem        <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
      end
      if (commit) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_rdata <= (c_we || mis) ? '0 : ld_data;
        resp_err   <= mis;
        if (c_we && !mis)
          for (int i = 0; i < 8; i++)
            if (4'(i) < nb) mem[{AW'(c_idx + AW'(i)), 3'b000} +: 8] <= c_wdata[8*i +: 8];
      end else if (accept) begin
        state <= WAIT;
        cnt   <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end else if (state == RESP && resp_ready) begin
        state      <= IDLE;
        resp_valid <= 1'b0;
      end
    end
  end
  assign dbg_byte0 = mem[7:0];
  assign dbg_byte1 = mem[15:8];
  assign dbg_byte2 = mem[23:16];
  assign dbg_byte3 = mem[31:24];
  assign dbg_byte4 = mem[39:32];
  assign dbg_byte5 = mem[47:40];
endmodule
